frame_update_sequencer: RTL and testbench

//   Per-frame scheduler for the game-object update datapath. Each frame it runs
//   a fixed sequence of steps on the shared object table:
//   - brick-table init, or
//   - one motion step, then a one-object-per-cycle collision scan.

---
 rtl/frame_update_sequencer.sv | 127 ++++++++++++
 tb/tb_frame_update_sequencer.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/frame_update_sequencer.sv
// frame_update_sequencer: per-frame scheduler for the game-object update datapath.
// Each frame, started by a rising edge of nextFrame, it either rebuilds the brick table
// (one brick per cycle) or issues a motion strobe and then scans the object table one
// entry per cycle, stopping at the first entry the ball reflects off.
// Ports:
//   clk, rst (async, active-low)
//   nextFrame, initReq                     frame start and init request
//   objIdx -> / objTag, hit <-             combinational table read / ball-hit result
//   motionEn                               motion strobe
//   wrEn, wrKind, wrIdx, brickRow, brickCol table write (null tag or brick init)
//   physEn, physHit, physIdx               reflection strobe and its source entry
//   busy, done, bricksLeft, clearedAll, overrun  status
module frame_update_sequencer #(
    parameter int OBJ_MAX    = 37,
    parameter int IDX_W      = 6,
    parameter int TAG_W      = 2,
    parameter int BRICK_BASE = 5,
    parameter int BRICK_ROWS = 4,
    parameter int BRICK_COLS = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             nextFrame,
    input  logic             initReq,
    output logic [IDX_W-1:0] objIdx,
    input  logic [TAG_W-1:0] objTag,
    input  logic [1:0]       hit,
    output logic             motionEn,
    output logic             wrEn,
    output logic             wrKind,
    output logic [IDX_W-1:0] wrIdx,
    output logic [1:0]       brickRow,
    output logic [2:0]       brickCol,
    output logic             physEn,
    output logic [1:0]       physHit,
    output logic [IDX_W-1:0] physIdx,
    output logic             busy,
    output logic             done,
    output logic [5:0]       bricksLeft,
    output logic             clearedAll,
    output logic             overrun
);
    typedef enum logic [2:0] {IDLE, INIT, MOTION, SCAN, DONE} state_t;

    localparam logic [TAG_W-1:0] TAG_NULL  = TAG_W'(0);
    localparam logic [TAG_W-1:0] TAG_BALL  = TAG_W'(2);
    localparam logic [TAG_W-1:0] TAG_BRICK = TAG_W'(3);

    state_t           state;
    logic             nf_q;
    logic             edge_q;
    logic [IDX_W-1:0] idx;
    logic [1:0]       row;
    logic [2:0]       col;
    logic             inited;
    logic             live;
    logic             brk;

    // Null and ball entries never reflect the ball, whatever hit says.
    assign live = (state == SCAN) && objTag != TAG_NULL && objTag != TAG_BALL && hit != 2'b00;
    assign brk  = live && objTag == TAG_BRICK;

    assign objIdx     = (state == SCAN) ? idx : '0;
    assign motionEn   = state == MOTION;
    assign wrEn       = (state == INIT) | brk;
    assign wrKind     = state == INIT;
    assign wrIdx      = (state == INIT) ? IDX_W'(BRICK_BASE + int'(row) * BRICK_COLS + int'(col)) :
                        brk ? idx : '0;
    assign brickRow   = (state == INIT) ? row : '0;
    assign brickCol   = (state == INIT) ? col : '0;
    assign physEn     = live;
    assign physHit    = live ? hit : 2'b00;
    assign physIdx    = live ? idx : '0;
    assign busy       = state != IDLE;
    assign done       = state == DONE;
    assign clearedAll = inited && bricksLeft == 6'd0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            nf_q       <= 1'b1;  // a level already high at reset release is not an edge
            edge_q     <= 1'b0;
            idx        <= '0;
            row        <= '0;
            col        <= '0;
            bricksLeft <= '0;
            inited     <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            nf_q   <= nextFrame;
            edge_q <= nextFrame & ~nf_q;
            if (edge_q && state != IDLE)
                overrun <= 1'b1;
            case (state)
                IDLE: if (edge_q) begin
                    row   <= '0;
                    col   <= '0;
                    state <= initReq ? INIT : MOTION;
                end
                INIT: if (col == 3'(BRICK_COLS - 1)) begin
                    col <= '0;
                    if (row == 2'(BRICK_ROWS - 1)) begin
                        bricksLeft <= 6'(BRICK_ROWS * BRICK_COLS);
                        inited     <= 1'b1;
                        state      <= DONE;
                    end else
                        row <= row + 2'd1;
                end else
                    col <= col + 3'd1;
                MOTION: begin
                    idx   <= '0;
                    state <= SCAN;
                end
                SCAN: if (live) begin
                    if (brk && bricksLeft != 6'd0)
                        bricksLeft <= bricksLeft - 6'd1;
                    state <= DONE;
                end else if (idx == IDX_W'(OBJ_MAX - 1))
                    state <= DONE;
                else
                    idx <= idx + 1'b1;
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_frame_update_sequencer.sv
// tb_frame_update_sequencer: directed self-checking bench with a small object-table model.
module tb_frame_update_sequencer;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       nextFrame = 1'b0;
    logic       initReq = 1'b0;
    logic [5:0] objIdx;
    logic [1:0] objTag;
    logic [1:0] hit;
    logic       motionEn, wrEn, wrKind, physEn, busy, done, clearedAll, overrun;
    logic [5:0] wrIdx, physIdx, bricksLeft;
    logic [1:0] brickRow, physHit;
    logic [2:0] brickCol;

    logic [1:0]  tags [0:63];
    logic [63:0] hmask = '0;
    logic [1:0]  hval = 2'b00;
    int          cnt = 0;
    int          errs = 0;

    frame_update_sequencer dut (
        .clk(clk), .rst(rst), .nextFrame(nextFrame), .initReq(initReq),
        .objIdx(objIdx), .objTag(objTag), .hit(hit), .motionEn(motionEn),
        .wrEn(wrEn), .wrKind(wrKind), .wrIdx(wrIdx), .brickRow(brickRow),
        .brickCol(brickCol), .physEn(physEn), .physHit(physHit), .physIdx(physIdx),
        .busy(busy), .done(done), .bricksLeft(bricksLeft), .clearedAll(clearedAll),
        .overrun(overrun)
    );

    always #5 clk = ~clk;

    always_comb begin
        objTag = tags[objIdx];
        hit    = hmask[objIdx] ? hval : 2'b00;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        cnt++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One play frame; stop < 0 means the scan runs to the last entry with no reflection.
    task automatic play(input int stop, input logic [1:0] eh, input logic ew, input int eleft);
        int last;
        int stray;
        last  = (stop < 0) ? 36 : stop;
        stray = 0;
        nextFrame = 1'b1;
        @(negedge clk);
        nextFrame = 1'b0;
        @(negedge clk);
        chk("motion", motionEn, 1);
        for (int i = 0; i <= last; i++) begin
            @(negedge clk);
            chk("objIdx", objIdx, i);
            if (i == stop) begin
                chk("physEn", physEn, 1);
                chk("physHit", physHit, eh);
                chk("physIdx", physIdx, i);
                chk("wrEn", wrEn, ew);
                if (ew) chk("wrKindIdx", {wrKind, wrIdx}, {1'b0, 6'(i)});
            end else
                stray += int'(physEn) + int'(wrEn) + int'(motionEn);
        end
        chk("stray", stray, 0);
        @(negedge clk);
        chk("done", done, 1);
        chk("left", bricksLeft, eleft);
        @(negedge clk);
        chk("idle", {busy, done}, 0);
    endtask

    initial begin
        int left;
        int seen;
        for (int i = 0; i < 64; i++) tags[i] = (i >= 5 && i <= 36) ? 2'd3 : 2'd0;
        tags[0] = 2'd2;
        tags[1] = 2'd1;
        repeat (3) @(negedge clk);
        chk("rst_status", {busy, done, overrun, clearedAll, bricksLeft}, 0);
        chk("rst_strobes", {motionEn, wrEn, wrKind, physEn, objIdx, wrIdx, physIdx}, 0);
        rst = 1'b1;
        @(negedge clk);

        // brick-table init
        initReq   = 1'b1;
        nextFrame = 1'b1;
        @(negedge clk);
        chk("init_lat", wrEn, 0);
        nextFrame = 1'b0;
        for (int k = 0; k < 32; k++) begin
            @(negedge clk);
            chk("init_wr", {wrEn, wrKind, wrIdx, brickRow, brickCol},
                {1'b1, 1'b1, 6'(5 + k), 2'(k / 8), 3'(k % 8)});
        end
        @(negedge clk);
        chk("init_done", {done, wrEn, motionEn}, 3'b100);
        chk("init_left", bricksLeft, 32);
        chk("init_clr", clearedAll, 0);
        @(negedge clk);
        chk("init_idle", busy, 0);
        initReq = 1'b0;

        play(-1, 2'b00, 1'b0, 32);

        hmask[10] = 1'b1;
        hval      = 2'b01;
        play(10, 2'b01, 1'b1, 31);
        tags[10]  = 2'd0;
        hmask[10] = 1'b0;

        hmask[1] = 1'b1;
        hval     = 2'b10;
        play(1, 2'b10, 1'b0, 31);
        hmask[1] = 1'b0;

        hval = 2'b11;
        hmask[0] = 1'b1; hmask[2] = 1'b1; hmask[3] = 1'b1; hmask[4] = 1'b1; hmask[10] = 1'b1;
        play(-1, 2'b00, 1'b0, 31);
        hmask = '0;
        chk("not_cleared", clearedAll, 0);

        hval = 2'b01;
        left = 31;
        for (int b = 5; b <= 36; b++) begin
            if (b != 10) begin
                hmask[b] = 1'b1;
                left--;
                play(b, 2'b01, 1'b1, left);
                tags[b]  = 2'd0;
                hmask[b] = 1'b0;
            end
        end
        chk("cleared", {clearedAll, bricksLeft}, {1'b1, 6'd0});

        // frame edge while scanning
        nextFrame = 1'b1;
        @(negedge clk);
        nextFrame = 1'b0;
        repeat (10) @(negedge clk);
        chk("ovr_before", overrun, 0);
        nextFrame = 1'b1;
        repeat (2) @(negedge clk);
        chk("ovr_set", overrun, 1);
        nextFrame = 1'b0;
        seen = 0;
        for (int i = 0; i < 40 && seen == 0; i++) begin
            @(negedge clk);
            if (done) seen = 1;
        end
        chk("ovr_done", seen, 1);
        seen = 0;
        repeat (5) begin
            @(negedge clk);
            seen += int'(busy) + int'(motionEn);
        end
        chk("ovr_norestart", seen, 0);
        chk("ovr_sticky", overrun, 1);

        // reset mid-INIT
        initReq   = 1'b1;
        nextFrame = 1'b1;
        repeat (5) @(negedge clk);
        chk("mid_init", {wrEn, wrKind}, 2'b11);
        rst = 1'b0;
        #1;
        chk("arst_status", {busy, done, overrun, clearedAll, bricksLeft}, 0);
        chk("arst_wr", {wrEn, wrKind, wrIdx, brickRow, brickCol}, 0);
        @(negedge clk);
        rst = 1'b1;
        repeat (4) @(negedge clk);
        chk("no_edge_at_release", {busy, wrEn}, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cnt, errs);
        $finish;
    end
endmodule
